// File: rtl/four_bit_alu.sv
// Registered ALU: A plus a select-shaped Y operand plus carry-in through a
// ripple-carry chain; D and Cout load on every rising clk edge.
module four_bit_alu #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             S1,
   input  logic             S0,
   input  logic             Cin,
   output logic [WIDTH-1:0] D,
   output logic             Cout
);

   typedef enum logic [1:0] {
      SEL_B     = 2'b00,
      SEL_NOT_B = 2'b01,
      SEL_ZERO  = 2'b10,
      SEL_ONES  = 2'b11
   } y_sel_e;

   y_sel_e           y_sel;
   logic [WIDTH-1:0] y;
   logic [WIDTH-1:0] sum;
   logic [WIDTH:0]   carry;

   assign y_sel = y_sel_e'({S1, S0});

   // NOTE: y gets a default before the case so no path leaves it unassigned,
   // which would infer a latch.
   always_comb begin
      y = B;
      unique case (y_sel)
         SEL_B:     y = B;
         SEL_NOT_B: y = ~B;
         SEL_ZERO:  y = '0;
         SEL_ONES:  y = '1;
         default:   y = B;
      endcase
   end

   // One full adder per bit; each stage consumes the previous stage's carry.
   assign carry[0] = Cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      logic p;
      assign p          = A[i] ^ y[i];
      assign sum[i]     = p ^ carry[i];
      assign carry[i+1] = (A[i] & y[i]) | (p & carry[i]);
   end

   // NOTE: registers use non-blocking assignments so every flop samples
   // values from before the edge, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         D    <= '0;
         Cout <= 1'b0;
      end else begin
         D    <= sum;
         Cout <= carry[WIDTH];
      end
   end

endmodule

// File: tb/tb_four_bit_alu.sv
// Self-checking bench for four_bit_alu: directed reset, sweep, wrap, hold and
// mid-run reset cases, then random vectors against an arithmetic model.
module tb_four_bit_alu;

   localparam int W    = 4;
   localparam int MASK = (1 << W) - 1;

   logic         clk;
   logic         clk_run;
   logic         rst;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         s1;
   logic         s0;
   logic         cin;
   logic [W-1:0] d;
   logic         cout;

   int checks = 0;
   int errors = 0;

   four_bit_alu #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .A    (a),
      .B    (b),
      .S1   (s1),
      .S0   (s0),
      .Cin  (cin),
      .D    (d),
      .Cout (cout)
   );

   initial clk = 1'b0;
   always #5 if (clk_run) clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: Y chosen by select, then plain integer addition.
   function automatic int model_sum(input int av, input int bv, input int sel, input int c);
      int yv;
      case (sel)
         0:       yv = bv;
         1:       yv = MASK - bv;
         2:       yv = 0;
         default: yv = MASK;
      endcase
      return av + yv + c;
   endfunction

   task automatic drive(input int av, input int bv, input int sel, input int c);
      a   = W'(av);
      b   = W'(bv);
      s1  = sel[1];
      s0  = sel[0];
      cin = c[0];
   endtask

   // Drive on a falling edge, check just after the following rising edge.
   task automatic apply(input string tag, input int av, input int bv, input int sel,
                        input int c, input int exp_d, input int exp_c);
      @(negedge clk);
      drive(av, bv, sel, c);
      @(posedge clk);
      #1;
      check({tag, "_d"}, int'(d), exp_d);
      check({tag, "_cout"}, int'(cout), exp_c);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int exp_d [8] = '{8, 9, 1, 2, 5, 6, 4, 5};
      int exp_c [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
      int ra, rb, rs, rc, r;

      clk_run = 1'b0;
      rst     = 1'b0;
      drive(10, 6, 3, 1);

      // Reset with the clock stopped must clear outputs at once.
      #2 rst = 1'b1;
      #1;
      check("rst_async_d", int'(d), 0);
      check("rst_async_cout", int'(cout), 0);
      drive(5, 3, 0, 0);
      #2 rst = 1'b0;
      #1;
      check("rst_release_hold_d", int'(d), 0);
      clk_run = 1'b1;
      @(posedge clk);
      #1;
      check("first_edge_d", int'(d), 8);
      check("first_edge_cout", int'(cout), 0);

      for (int i = 0; i < 8; i++)
         apply($sformatf("sweep%0d", i), 5, 3, i / 2, i % 2, exp_d[i], exp_c[i]);

      apply("wrap_add", 15, 1, 0, 0, 0, 1);
      apply("wrap_dec", 0, 9, 3, 0, 15, 0);
      apply("borrow", 3, 5, 1, 1, 14, 0);

      // Inputs changed between edges must not disturb the registered result.
      apply("hold_pre", 5, 3, 0, 1, 9, 0);
      @(negedge clk);
      drive(12, 7, 1, 0);
      #2;
      check("hold_d", int'(d), 9);
      check("hold_cout", int'(cout), 0);
      @(posedge clk);
      #1;
      check("hold_next_d", int'(d), 4);
      check("hold_next_cout", int'(cout), 1);

      // Mid-run reset pulse between edges.
      apply("midrst_pre", 5, 3, 2, 0, 5, 0);
      @(negedge clk);
      drive(7, 2, 0, 1);
      #1 rst = 1'b1;
      #1;
      check("midrst_d", int'(d), 0);
      check("midrst_cout", int'(cout), 0);
      #1 rst = 1'b0;
      #1;
      check("midrst_held_d", int'(d), 0);
      @(posedge clk);
      #1;
      check("midrst_load_d", int'(d), 10);
      check("midrst_load_cout", int'(cout), 0);

      for (int i = 0; i < 1000; i++) begin
         ra = int'($urandom_range(MASK, 0));
         rb = int'($urandom_range(MASK, 0));
         rs = int'($urandom_range(3, 0));
         rc = int'($urandom_range(1, 0));
         r  = model_sum(ra, rb, rs, rc);
         apply("rand", ra, rb, rs, rc, r % (MASK + 1), r / (MASK + 1));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
